// File: rtl/arm_mem_pkg.sv
// rtl/arm_mem_pkg.sv - shared types for the camera/CPU memory arbiter
//   grant_t     : which requester owns the memory port this cycle
//   arb_state_t : CPU load sequencing (IDLE, RD_DATA)
//   cam_wr_t    : one buffered pixel write at the default 32/32 widths
package arm_mem_pkg;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_CPU,
        GNT_CAM
    } grant_t;

    typedef enum logic {
        IDLE,
        RD_DATA
    } arb_state_t;

    localparam int CAM_WR_ADDR_W = 32;
    localparam int CAM_WR_DATA_W = 32;

    typedef struct packed {
        logic [CAM_WR_ADDR_W-1:0] addr;
        logic [CAM_WR_DATA_W-1:0] data;
    } cam_wr_t;

endpackage

// File: rtl/cam_write_fifo.sv
// rtl/cam_write_fifo.sv - camera pixel write FIFO
//   clk, reset    : clock, asynchronous active-low reset (empties the FIFO)
//   push/pushData : enqueue when push && !full
//   pop/popData   : popData shows the head; dequeue when pop && !empty
//   full, empty   : occupancy flags
//   level         : occupancy, 0..DEPTH
module cam_write_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         pushData,
    input  logic                     pop,
    output logic [WIDTH-1:0]         popData,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic             doPush;
    logic             doPop;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign doPush  = push && !full;
    assign doPop   = pop && !empty;
    // Head is read from storage only, so a push is never visible the same cycle.
    assign popData = storage[rdPtr];

    always_ff @(posedge clk) begin
        if (doPush) begin
            storage[wrPtr] <= pushData;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            level <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            case ({doPush, doPop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/camera_mem_arbiter.sv
// rtl/camera_mem_arbiter.sv - shares one synchronous RAM port between CPU and camera
//   cpu_*      : memory-stage request, load data and pipeline stall
//   cam_*      : valid/ready pixel write stream into the camera FIFO
//   mem_*      : single RAM port, combinational from the grant; read data one cycle later
//   fifo_level : camera FIFO occupancy
module camera_mem_arbiter
    import arm_mem_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int CAM_FIFO_DEPTH = 4,
    parameter int CAM_MAX_WAIT   = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            cpu_req,
    input  logic                            cpu_we,
    input  logic [ADDR_W-1:0]               cpu_addr,
    input  logic [DATA_W-1:0]               cpu_wdata,
    output logic [DATA_W-1:0]               cpu_rdata,
    output logic                            cpu_stall,
    input  logic                            cam_valid,
    output logic                            cam_ready,
    input  logic [ADDR_W-1:0]               cam_addr,
    input  logic [DATA_W-1:0]               cam_data,
    output logic                            mem_en,
    output logic                            mem_we,
    output logic [ADDR_W-1:0]               mem_addr,
    output logic [DATA_W-1:0]               mem_wdata,
    input  logic [DATA_W-1:0]               mem_rdata,
    output logic [$clog2(CAM_FIFO_DEPTH):0] fifo_level
);

    localparam int WAIT_W = $clog2(CAM_MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] MAX_WAIT_CNT = WAIT_W'(CAM_MAX_WAIT);

    arb_state_t                 state;
    arb_state_t                 nextState;
    grant_t                     grant;
    logic [WAIT_W-1:0]          waitCnt;
    logic                       forceCam;
    logic                       fifoFull;
    logic                       fifoEmpty;
    logic                       fifoPush;
    logic                       fifoPop;
    logic [ADDR_W+DATA_W-1:0]   fifoHead;

    assign cam_ready = reset && !fifoFull;
    assign fifoPush  = cam_valid && cam_ready;
    assign fifoPop   = (grant == GNT_CAM);

    cam_write_fifo #(
        .DEPTH (CAM_FIFO_DEPTH),
        .WIDTH (ADDR_W + DATA_W)
    ) u_camFifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fifoPush),
        .pushData ({cam_addr, cam_data}),
        .pop      (fifoPop),
        .popData  (fifoHead),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .level    (fifo_level)
    );

    assign forceCam = !fifoEmpty && (fifoFull || (waitCnt == MAX_WAIT_CNT));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        grant     = GNT_NONE;
        nextState = state;
        case (state)
            IDLE: begin
                if (forceCam) begin
                    grant = GNT_CAM;
                end else if (cpu_req) begin
                    grant = GNT_CPU;
                end else if (!fifoEmpty) begin
                    grant = GNT_CAM;
                end
                if (grant == GNT_CPU && !cpu_we) begin
                    nextState = RD_DATA;
                end
            end
            RD_DATA: begin
                // The CPU only collects read data here, so the port is free to drain a pixel.
                if (!fifoEmpty) begin
                    grant = GNT_CAM;
                end
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
        // Outputs must read zero for the whole reset window, not only after a clock edge.
        if (!reset) begin
            grant = GNT_NONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            waitCnt <= '0;
        end else if (fifoEmpty || grant == GNT_CAM) begin
            waitCnt <= '0;
        end else if (waitCnt != MAX_WAIT_CNT) begin
            waitCnt <= waitCnt + WAIT_W'(1);
        end
    end

    always_comb begin
        mem_en    = (grant != GNT_NONE);
        mem_we    = (grant == GNT_CAM) || (grant == GNT_CPU && cpu_we);
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant == GNT_CAM) begin
            mem_addr  = fifoHead[ADDR_W+DATA_W-1:DATA_W];
            mem_wdata = fifoHead[DATA_W-1:0];
        end else if (grant == GNT_CPU) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end
    end

    // Only a granted store lets the CPU proceed from IDLE; loads and lost arbitration stall.
    assign cpu_stall = reset && (state == IDLE) && cpu_req && !(grant == GNT_CPU && cpu_we);
    assign cpu_rdata = (state == RD_DATA) ? mem_rdata : '0;

endmodule
